led_flow_ctrl: RTL and testbench
================================

# led_flow_ctrl

Mode/speed controller for the board's 4-bit LED bank. It sequences a set of display patterns (off, flow-left, flow-right, blink, and an optional ping-pong bounce) from three debounced key pulses. It generates the step strobe at one of four selectable rates and supports pause/resume. It sits between the key-debounce blocks and the LED pins, replacing a free-running single-pattern flow driver.

## Interface
- TICK_MAX, 25'd7_999_999, terminal count of the slowest step period; period = TICK_MAX+1 cycles; TICK_MAX+1 must be a multiple of 8 and ≥ 8
- sys_clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- key_mode  in  1  single-cycle pulse: advance to next mode
- key_speed  in  1  single-cycle pulse: advance speed 0→1→2→3→0
- key_pause  in  1  single-cycle pulse: toggle pause
- led  out  4  LED drive, 1 = lit
- mode  out  3  current mode encoding
- tick  out  1  registered one-cycle step strobe
- paused  out  1  1 while stepping is frozen

## Operation
- Modes:
  - OFF=0: led 0000.
  - FLOW_L=1: load 0001, rotate left ({led[2:0],led[3]}).
  - FLOW_R=2: load 1000, rotate right.
  - BLINK=3: load 1111, invert each step.
  - PINGPONG=4: load 0001, shift toward bit 3, reverse at 1000, shift back, reverse at 0001.
- Mode order: OFF→FLOW_L→FLOW_R→BLINK→(PINGPONG)→OFF.
- key_mode: mode advances, the mode's load pattern is written to led, step counter cleared to 0, pause cleared, PINGPONG direction set to "up". All take effect on the same edge.
- key_speed: speed register advances (wraps 3→0); step counter cleared to 0; led unchanged.
- key_pause: toggles paused. While paused, counter holds, tick stays 0, led holds.
- Simultaneous pulses:
  - key_mode and key_speed are both applied.
  - key_pause is ignored in any cycle where key_mode is high.
- Step counter: 25 bits, counts 0..LIMIT then wraps to 0; LIMIT = ((TICK_MAX+1) >> speed) − 1.
- In OFF, the counter and tick still run; led stays 0000.
- Reset values: led 0000, mode 0 (OFF), tick 0, paused 0, speed 0, counter 0, direction up.
- Reset asserted mid-step returns everything to the reset values immediately, asynchronously.

## Timing
- tick is high for exactly one cycle, in the cycle after the counter equals LIMIT.
- led updates on the clock edge that ends the cycle in which tick is high, so led changes 2 edges after the counter reaches LIMIT.
- Step period is exactly (TICK_MAX+1)>>speed cycles. At speed 3 with TICK_MAX=7, tick is high every cycle.
- A key pulse in cycle k is visible on mode/paused/led (load pattern) after edge k+1.
- A key_mode/key_speed pulse coincident with counter==LIMIT suppresses the tick that would follow: the counter clear wins.
- If tick is already high in the cycle of key_mode, the load pattern wins over the step.
- paused and tick are mutually exclusive. A tick already registered when pause asserts is discarded: led does not step.

## Configuration
- LED_PINGPONG_EN defined: PINGPONG mode is present; order wraps BLINK→PINGPONG→OFF; mode reaches 4.
- LED_PINGPONG_EN undefined: no direction register or PINGPONG logic; BLINK→OFF; mode never exceeds 3.

## Structure
- Package led_flow_pkg holds:
  - mode encodings: MODE_OFF, MODE_FLOW_L, MODE_FLOW_R, MODE_BLINK, MODE_PINGPONG
  - CNT_W = 25
  - load patterns: PAT_FLOW_L = 4'b0001, PAT_FLOW_R = 4'b1000, PAT_BLINK = 4'b1111
- Sub-module led_tick_gen: counter, speed-shifted LIMIT, clear and hold inputs, registered tick output.
- The top level holds the mode FSM, pause toggle and LED pattern register.

## Test plan
All scenarios use TICK_MAX=7.
- Reset, no keys, 40 cycles → led 0000, mode 0, tick pulses every 8 cycles, paused 0.
- One key_mode → mode 1, led 0001; after 4 ticks led sequence is 0010, 0100, 1000, 0001, with each change exactly 8 cycles apart.
- Mode FLOW_R, key_speed ×2 → speed 2, ticks every 2 cycles, led 1000→0100→0010; key_speed ×2 more → back to 8-cycle period.
- Mode BLINK, key_pause mid-period → led frozen at current value, tick 0 for 30 cycles; key_pause again → stepping resumes, counter continues from its held value.
- key_mode and key_pause in the same cycle while paused in FLOW_L → mode 2, led 1000, paused 0. Repeat with key_mode pulsed in the cycle where tick is high → load pattern appears, no extra step.
- With LED_PINGPONG_EN: 4 key_mode → mode 4, led sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. Without the macro: 4 key_mode → mode 0, led 0000. Assert rst_n low mid-sequence → all outputs at reset values immediately.

Source files
------------

// File: rtl/led_flow_pkg.sv
// led_flow_pkg: shared mode encodings, counter width and load patterns for the LED flow controller.
package led_flow_pkg;

    localparam int CNT_W = 25;

    typedef enum logic [2:0] {
        MODE_OFF      = 3'd0,
        MODE_FLOW_L   = 3'd1,
        MODE_FLOW_R   = 3'd2,
        MODE_BLINK    = 3'd3,
        MODE_PINGPONG = 3'd4
    } mode_t;

    localparam logic [3:0] PAT_FLOW_L = 4'b0001;
    localparam logic [3:0] PAT_FLOW_R = 4'b1000;
    localparam logic [3:0] PAT_BLINK  = 4'b1111;

    function automatic logic [3:0] load_pat(mode_t m);
        return (m == MODE_FLOW_L || m == MODE_PINGPONG) ? PAT_FLOW_L :
               (m == MODE_FLOW_R)                       ? PAT_FLOW_R :
               (m == MODE_BLINK)                        ? PAT_BLINK  : 4'b0000;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: step counter with speed-shifted terminal count, clear/hold inputs and a registered tick.
module led_tick_gen
    import led_flow_pkg::*;
#(
    parameter logic [CNT_W-1:0] TICK_MAX = 25'd7_999_999
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    input  logic       clr,
    input  logic       hold,
    output logic       tick
);

    localparam logic [CNT_W:0] PERIOD = {1'b0, TICK_MAX} + 1'b1;

    logic [CNT_W:0]   period_s;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             at_lim;

    assign period_s = PERIOD >> speed;
    assign limit    = CNT_W'(period_s - 1'b1);
    assign at_lim   = cnt_q == limit;

    // A clear outranks the terminal count, so a key press on LIMIT swallows that tick.
    always_comb begin
        cnt_d  = clr ? '0 : hold ? cnt_q : at_lim ? '0 : cnt_q + 1'b1;
        tick_d = !clr && !hold && at_lim;
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/led_flow_ctrl.sv
// led_flow_ctrl: key-driven LED pattern sequencer with four step rates and pause.
// Define LED_PINGPONG_EN to add the ping-pong bounce mode after BLINK.
module led_flow_ctrl
    import led_flow_pkg::*;
#(
    parameter logic [CNT_W-1:0] TICK_MAX = 25'd7_999_999
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_speed,
    input  logic       key_pause,
    output logic [3:0] led,
    output logic [2:0] mode,
    output logic       tick,
    output logic       paused
);

    mode_t      mode_q, mode_d, mode_nxt;
    logic [3:0] led_q, led_d, led_step;
    logic [1:0] speed_q, speed_d;
    logic       paused_q, paused_d;
    logic       step;

`ifdef LED_PINGPONG_EN
    logic dir_q, dir_d;
    logic going_up;

    // Bounce turns around at either end of the bank.
    assign going_up = dir_q ? (led_q != 4'b1000) : (led_q == 4'b0001);
    assign mode_nxt = (mode_q == MODE_PINGPONG) ? MODE_OFF : mode_t'(mode_q + 3'd1);
`else
    assign mode_nxt = (mode_q == MODE_BLINK) ? MODE_OFF : mode_t'(mode_q + 3'd1);
`endif

    always_comb begin
        led_step = led_q;
        case (mode_q)
            MODE_FLOW_L:   led_step = {led_q[2:0], led_q[3]};
            MODE_FLOW_R:   led_step = {led_q[0], led_q[3:1]};
            MODE_BLINK:    led_step = ~led_q;
`ifdef LED_PINGPONG_EN
            MODE_PINGPONG: led_step = going_up ? led_q << 1 : led_q >> 1;
`endif
            default:       led_step = led_q;
        endcase
    end

    // A tick arriving as pause engages is dropped rather than stepped.
    always_comb begin
        paused_d = key_mode ? 1'b0 : paused_q ^ key_pause;
        speed_d  = speed_q + {1'b0, key_speed};
        mode_d   = key_mode ? mode_nxt : mode_q;
        step     = tick && !paused_d;
        led_d    = key_mode ? load_pat(mode_nxt) : step ? led_step : led_q;
`ifdef LED_PINGPONG_EN
        dir_d    = key_mode ? 1'b1 : (step && mode_q == MODE_PINGPONG) ? going_up : dir_q;
`endif
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q   <= MODE_OFF;
            led_q    <= 4'b0000;
            speed_q  <= 2'd0;
            paused_q <= 1'b0;
`ifdef LED_PINGPONG_EN
            dir_q    <= 1'b1;
`endif
        end else begin
            mode_q   <= mode_d;
            led_q    <= led_d;
            speed_q  <= speed_d;
            paused_q <= paused_d;
`ifdef LED_PINGPONG_EN
            dir_q    <= dir_d;
`endif
        end
    end

    led_tick_gen #(.TICK_MAX(TICK_MAX)) u_tick (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .speed   (speed_q),
        .clr     (key_mode | key_speed),
        .hold    (paused_d),
        .tick    (tick)
    );

    assign led    = led_q;
    assign mode   = mode_q;
    assign paused = paused_q;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// tb_led_flow_ctrl: randomized and directed check of led_flow_ctrl against a behavioural model (TICK_MAX=7).
module tb_led_flow_ctrl;

    localparam int TMAX = 7;
`ifdef LED_PINGPONG_EN
    localparam int NMODES = 5;
`else
    localparam int NMODES = 4;
`endif

    logic       sys_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_mode = 1'b0, key_speed = 1'b0, key_pause = 1'b0;
    logic [3:0] led;
    logic [2:0] mode;
    logic       tick, paused;

    led_flow_ctrl #(.TICK_MAX(25'd7)) dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .key_mode  (key_mode),
        .key_speed (key_speed),
        .key_pause (key_pause),
        .led       (led),
        .mode      (mode),
        .tick      (tick),
        .paused    (paused)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0, passes = 0;

    // Model state: counter position within the current period, plus display state.
    int m_mode = 0, m_led = 0, m_speed = 0, m_cnt = 0, m_pp = 0;
    bit m_tick = 0, m_paused = 0;
    int pp_seq[6] = '{1, 2, 4, 8, 4, 2};
    int period;
    bit clr, np, nt;

    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_led = 0; m_speed = 0; m_cnt = 0; m_pp = 0;
            m_tick = 0; m_paused = 0;
        end else begin
            period = (TMAX + 1) >> m_speed;
            clr = key_mode || key_speed;
            np  = key_mode ? 1'b0 : (key_pause ? !m_paused : m_paused);
            nt  = !clr && !np && (m_cnt == period - 1);
            if (key_mode) begin
                m_mode = (m_mode + 1) % NMODES;
                m_pp   = 0;
                m_led  = (m_mode == 1 || m_mode == 4) ? 1 : (m_mode == 2) ? 8 : (m_mode == 3) ? 15 : 0;
            end else if (m_tick && !np) begin
                case (m_mode)
                    1: m_led = ((m_led << 1) | (m_led >> 3)) & 15;
                    2: m_led = ((m_led >> 1) | (m_led << 3)) & 15;
                    3: m_led = m_led ^ 15;
                    4: begin m_pp = (m_pp + 1) % 6; m_led = pp_seq[m_pp]; end
                    default: m_led = 0;
                endcase
            end
            m_cnt    = clr ? 0 : np ? m_cnt : (m_cnt + 1) % period;
            m_speed  = key_speed ? (m_speed + 1) % 4 : m_speed;
            m_tick   = nt;
            m_paused = np;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic compare();
        chk("led", int'(led), m_led);
        chk("mode", int'(mode), m_mode);
        chk("tick", int'(tick), int'(m_tick));
        chk("paused", int'(paused), int'(m_paused));
    endtask

    task automatic cyc(input bit km, input bit ks, input bit kp);
        @(negedge sys_clk);
        compare();
        key_mode = km; key_speed = ks; key_pause = kp;
    endtask

    task automatic measure(output int iv);
        int first;
        first = -1;
        iv = -1;
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, 0);
            if (tick) begin
                if (first < 0) first = i;
                else begin iv = i - first; break; end
            end
        end
    endtask

    int iv, prev, t_last, k, nticks, held;
    int seq_l[4] = '{2, 4, 8, 1};
    int seq_pp[7] = '{2, 4, 8, 4, 2, 1, 2};

    initial begin
        repeat (3) @(negedge sys_clk);
        chk("rst_led", int'(led), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_paused", int'(paused), 0);
        rst_n = 1'b1;
        measure(iv);
        chk("period_s0", iv, 8);

        cyc(1, 0, 0); cyc(0, 0, 0);
        chk("flowl_mode", int'(mode), 1);
        chk("flowl_load", int'(led), 1);
        prev = led; t_last = -1; k = 0;
        for (int i = 0; i < 60 && k < 4; i++) begin
            cyc(0, 0, 0);
            if (int'(led) != prev) begin
                chk("flowl_seq", int'(led), seq_l[k]);
                if (k > 0) chk("flowl_gap", i - t_last, 8);
                t_last = i; prev = led; k++;
            end
        end
        chk("flowl_steps", k, 4);

        cyc(1, 0, 0); cyc(0, 1, 0); cyc(0, 1, 0);
        measure(iv);
        chk("period_s2", iv, 2);
        cyc(0, 1, 0); cyc(0, 1, 0);
        measure(iv);
        chk("period_s0_again", iv, 8);

        cyc(1, 0, 0); repeat (3) cyc(0, 0, 0);
        cyc(0, 0, 1); cyc(0, 0, 0);
        chk("pause_on", int'(paused), 1);
        held = led; nticks = 0;
        for (int i = 0; i < 30; i++) begin
            cyc(0, 0, 0);
            if (tick) nticks++;
        end
        chk("pause_ticks", nticks, 0);
        chk("pause_led", int'(led), held);
        cyc(0, 0, 1);
        measure(iv);
        chk("period_resume", iv, 8);

        for (int i = 0; i < 6 && mode != 3'd1; i++) begin cyc(1, 0, 0); cyc(0, 0, 0); end
        cyc(0, 0, 1); repeat (3) cyc(0, 0, 0);
        cyc(1, 0, 1); cyc(0, 0, 0);
        chk("mp_mode", int'(mode), 2);
        chk("mp_led", int'(led), 8);
        chk("mp_paused", int'(paused), 0);

        for (int i = 0; i < 20 && !tick; i++) cyc(0, 0, 0);
        chk("tick_seen", int'(tick), 1);
        key_mode = 1'b1;
        cyc(0, 0, 0);
        chk("tickmode_mode", int'(mode), 3);
        chk("tickmode_led", int'(led), 15);

        for (int i = 0; i < 6 && mode != 3'd0; i++) begin cyc(1, 0, 0); cyc(0, 0, 0); end
        repeat (4) begin cyc(1, 0, 0); cyc(0, 0, 0); end
`ifdef LED_PINGPONG_EN
        chk("four_modes", int'(mode), 4);
        chk("pp_load", int'(led), 1);
        prev = led; k = 0;
        for (int i = 0; i < 80 && k < 7; i++) begin
            cyc(0, 0, 0);
            if (int'(led) != prev) begin chk("pp_seq", int'(led), seq_pp[k]); prev = led; k++; end
        end
        chk("pp_steps", k, 7);
`else
        chk("four_modes", int'(mode), 0);
        chk("off_led", int'(led), 0);
`endif

        for (int i = 0; i < 2000; i++)
            cyc($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0, $urandom_range(0, 24) == 0);

        cyc(1, 0, 0); cyc(0, 1, 0); repeat (3) cyc(0, 0, 0);
        @(posedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_led", int'(led), 0);
        chk("arst_mode", int'(mode), 0);
        chk("arst_tick", int'(tick), 0);
        chk("arst_paused", int'(paused), 0);
        repeat (3) cyc(0, 0, 0);
        rst_n = 1'b1;
        repeat (20) cyc(0, 0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
